// File: rtl/adders_pkg.sv
// Shared definitions for the adders/ arithmetic blocks: multiplier state encoding and iteration count.
package adders_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_ITER = 32;
    localparam int CNT_W     = $clog2(MULT_ITER);
endpackage

// File: rtl/RCA_32bit.sv
// 32-bit ripple-carry adder: a chain of full adders, purely combinational.
module RCA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    logic [32:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[32];
endmodule

// File: rtl/shift_add_mult_32.sv
// Sequential 32x32 unsigned shift-and-add multiplier built around RCA_32bit.
// One add/shift per cycle, 32 iterations, single-cycle done pulse with a registered product.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured when start is seen
//   CALC  | one add-and-shift per cycle, busy high, 32 cycles
//   DONE  | product just updated, done high for this cycle only
module shift_add_mult_32
    import adders_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    mult_state_t          state_q;
    logic [WIDTH-1:0]     m_q;
    logic [2*WIDTH:0]     p_q;
    logic [2*WIDTH:0]     p_next;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     sum;
    logic                 c_out;

    RCA_32bit u_rca (
        .a     (p_q[2*WIDTH-1:WIDTH]),
        .b     (m_q),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    // p_q[64] only ever holds a transient carry; it is shifted down each cycle
    always_comb begin
        p_next = {1'b0, p_q[2*WIDTH:1]};
        if (p_q[0]) begin
            p_next = {1'b0, c_out, sum, p_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state_q)
                // DONE behaves like IDLE so a held start is taken back-to-back
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_q     <= a;
                        p_q     <= {{(WIDTH+1){1'b0}}, b};
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    p_q   <= p_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MULT_ITER - 1)) begin
                        product <= p_next[2*WIDTH-1:0];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult_32.sv
// Scoreboard bench for shift_add_mult_32: stimulus pushes expected products, a negedge monitor checks them.
module tb_shift_add_mult_32;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_run = 0;
    logic [63:0] exp_q[$];

    shift_add_mult_32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation; busy must have run exactly 32 cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                done_cnt++;
                check("done_busy_low", {63'b0, busy}, 64'd0);
                check("busy_len", 64'(busy_run), 64'd32);
                busy_run = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got product %h with no expectation queued", product);
                end else begin
                    check("product", product, exp_q.pop_front());
                end
            end
        end
    end

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] expv, input bit push);
        @(posedge clk);
        #1;
        start = 1'b1;
        a = av;
        b = bv;
        if (push) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av;
        b = ~bv;
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, {63'b0, got}, 64'd1);
    endtask

    task automatic run_mult(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic [63:0] expv);
        start_op(av, bv, expv, 1'b1);
        wait_done(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        d0 = done_cnt;
        repeat (40) @(posedge clk);
        check("idle_no_done", 64'(done_cnt - d0), 64'd0);

        run_mult("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        run_mult("mix1", 32'h0000830A, 32'h000AE24C, 64'h000000059239BAF8);
        run_mult("mix2", 32'h00000001, 32'h0AEF1843, 64'h000000000AEF1843);
        run_mult("mix3", 32'h00000000, 32'hEFA123FF, 64'h0);

        // a second start while busy must be ignored
        start_op(32'd3, 32'd5, 64'd15, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        a = 32'd7;
        b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        d0 = done_cnt;
        wait_done("ignore");
        repeat (5) @(negedge clk);
        check("ignore_single_done", 64'(done_cnt - d0), 64'd1);

        // start held high across done: next multiply taken at the edge leaving DONE
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 32'd7;
        b = 32'd9;
        exp_q.push_back(64'd63);
        @(posedge clk);
        wait_done("held1");
        exp_q.push_back(64'd63);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_accept_busy", {63'b0, busy}, 64'd1);
        wait_done("held2");

        // reset mid-operation abandons the multiply
        start_op(32'hEFA123FF, 32'hF1293EFA, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_product", product, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

        run_mult("post_rst", 32'd2, 32'd3, 64'd6);

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_total", 64'(done_cnt), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
